fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decoder. Owns the PC and issues word
//  requests to instruction memory with a valid/ready handshake. Buffers returned
//  words in a small in-order queue and presents them as inst/inst_pc/inst_valid.
//  Downstream pulses nxt to consume; redirect from branch/jump flushes and restarts.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  QDEPTH     4              instruction queue entries (power of 2, >=2)
//  MAX_OUT    2              max outstanding imem requests (<= QDEPTH)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   reset, synchronous, active-high
//  imem_req_valid  out  1   request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_addr       out  32  word-aligned fetch address (current PC)
//  imem_rsp_valid  in   1   response data valid (in request order, >=1 cycle after accept)
//  imem_rsp_data   in   32  returned instruction word
//  redirect_valid  in   1   control-flow redirect
//  redirect_pc     in   32  new PC (bits[1:0] ignored, forced 0)
//  inst            out  32  head-of-queue instruction to decoder
//  inst_pc         out  32  PC of inst
//  inst_valid      out  1   queue non-empty
//  nxt             in   1   downstream consumes head when inst_valid&&nxt
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, outstanding=0, discard=0; inst_valid=0,
//   inst=32'h0000_0013 (NOP), inst_pc=0, imem_req_valid=0 during rst cycle.
//  Request: imem_req_valid = !rst && !redirect_valid && (count+outstanding < QDEPTH)
//   && (outstanding < MAX_OUT). Accept = valid&&ready -> pc+=4, outstanding+1.
//   imem_addr==pc, stable while valid&&!ready. pc wraps 32'hFFFF_FFFC -> 0.
//  Response: if discard>0 -> discard-1, word dropped; else push {word, pc_of_req}
//   into queue. Request PCs tracked in a MAX_OUT-deep tag FIFO. Credit rule
//   guarantees queue never overflows; rsp with outstanding==0 is ignored
//   (assertion fires in sim).
//  Pop: inst_valid&&nxt -> head advances next cycle. Empty: inst=NOP, inst_valid=0.
//   nxt with empty queue has no effect.
//  Latency: accept at cycle N, rsp at N+k -> inst_valid at N+k+1 if queue was empty.
//  Simultaneous push+pop: both occur, count unchanged. Push into empty + nxt same
//   cycle: nxt does not pop the not-yet-visible entry.
//  Redirect (highest priority): next cycle pc=redirect_pc&~3, queue flushed,
//   discard += outstanding (including an rsp arriving that same cycle, which is
//   dropped), outstanding=0, no request issued in redirect cycle, pending nxt ignored.
//  Back-to-back redirects: last one wins; discard accumulates correctly.
//  rst mid-operation: all state cleared next edge; in-flight responses after reset
//   are ignored by outstanding==0 rule.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (words pushed) and
//   perf_stall[31:0] (cycles with inst_valid==0 and !rst); both cleared by rst,
//   redirect does not clear; saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  core_pkg: XLEN=32, INST_NOP=32'h0000_0013, fetch_entry_t {inst, pc} struct.
//  Sub-module fetch_queue: sync FIFO of fetch_entry_t, QDEPTH, push/pop/flush,
//   count, full/empty; reused for request-PC tag FIFO (depth MAX_OUT).
//  Top: PC register, credit/outstanding/discard counters, request logic.
// TESTING
//  1 rst, ready=1, rsp 1 cycle later, nxt=1 -> inst_pc 0,4,8,... one per cycle, inst=mem.
//  2 nxt=0 -> exactly QDEPTH=4 words fetched, req_valid drops, queue full, no overflow.
//  3 2 requests in flight, redirect_pc=32'h100 -> both rsps dropped, next inst_pc=0x100.
//  4 ready=0 for 3 cycles -> imem_addr stable, pc not advanced; inst_valid=0, inst=NOP.
//  5 redirect and rsp same cycle, then rst during fetch -> word dropped; after rst pc=RESET_PC.
//  6 FETCH_PERF_CNT_EN: 10 words fetched, 3 empty cycles -> perf_fetched=10, perf_stall=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: XLEN, the NOP encoding presented
// while the instruction queue is empty, and the queue entry layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous in-order FIFO with flush. It holds fetched {inst, pc} entries and,
// with T set to a bare PC, also serves as the request tag FIFO.
module fetch_queue
  import core_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Explicit wrap, so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order queue to the
// decoder. Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            nxt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall
`endif
);

  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] disc_q, disc_d;

  fetch_entry_t    q_head, q_push_data;
  logic            q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0]  q_count;

  logic [XLEN-1:0] tag_head;
  logic            tag_push, tag_pop, tag_full, tag_empty;
  logic [OCW-1:0]  out_cnt;

  logic            credit_ok, req_accept, rsp_drop, rsp_live;

  // Outstanding count is the tag FIFO occupancy: one tag per accepted, unanswered request.
  always_comb begin
    credit_ok      = (32'(q_count) + 32'(out_cnt)) < 32'(QDEPTH);
    imem_req_valid = !rst && !redirect_valid && credit_ok && !tag_full;
    req_accept     = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (disc_q != '0);
    rsp_live       = imem_rsp_valid && (disc_q == '0) && !tag_empty;

    inst_valid  = !rst && !q_empty;
    q_pop       = inst_valid && nxt && !redirect_valid;
    q_push      = rsp_live && !redirect_valid && !q_full;
    q_push_data = '{inst: imem_rsp_data, pc: tag_head};
    tag_push    = req_accept;
    tag_pop     = rsp_live && !redirect_valid;

    pc_d   = pc_q;
    disc_d = disc_q;
    if (redirect_valid) begin
      // Everything still in flight becomes junk, minus a response consumed this cycle.
      pc_d   = redirect_pc & ~32'h3;
      disc_d = disc_q + 32'(out_cnt) - 32'(rsp_drop || rsp_live);
    end else begin
      if (req_accept) pc_d = pc_q + 32'd4;
      if (rsp_drop)   disc_d = disc_q - 32'd1;
    end

    imem_addr = pc_q;
    inst      = inst_valid ? q_head.inst : INST_NOP;
    inst_pc   = inst_valid ? q_head.pc : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      disc_q <= disc_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .T(fetch_entry_t)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  fetch_queue #(.DEPTH(MAX_OUT), .T(logic [XLEN-1:0])) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (pc_q),
    .pop       (tag_pop),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (out_cnt),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // A response with nothing outstanding and nothing to discard is a memory protocol error.
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) assert (disc_q != '0 || !tag_empty);
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
  logic [XLEN-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (q_push && perf_fetched_q != '1)              perf_fetched_d = perf_fetched_q + 32'd1;
    if (!inst_valid && !rst && perf_stall_q != '1)   perf_stall_d   = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
